uart_tx_frame: RTL and testbench

Parametrised UART serialiser replacing the fixed-format transmitter in the UART datapath. It accepts one data word per valid/ready handshake, frames it with start bit, 5..MAX_DATA_BITS data bits (LSB first), optional even/odd parity and one or two stop bits. Each bit lasts OVERSAMPLE baud ticks, counted internally. Status outputs feed the UART status register, and a break generator drives the line low on request.

---
 rtl/uart_tx_frame.sv | 151 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART frame serialiser: start, 5..MAX_DATA_BITS data (LSB first), optional parity, 1/2 stop, plus break.
// Line is registered and follows the bit state one clk later; each bit lasts OVERSAMPLE baud ticks.
module uart_tx_frame #(
  parameter int MAX_DATA_BITS = 9,
  parameter int OVERSAMPLE    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     baud_tick,
  input  logic [3:0]               cfg_data_bits,
  input  logic                     cfg_parity_en,
  input  logic                     cfg_parity_odd,
  input  logic                     cfg_stop_two,
  input  logic                     cfg_break,
  input  logic [MAX_DATA_BITS-1:0] tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     tx,
  output logic                     busy,
  output logic                     done
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(MAX_DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t                   state, state_nx;
  logic [TW-1:0]            tick_cnt, tick_nx;
  logic [IW-1:0]            bit_idx, idx_nx;
  logic [MAX_DATA_BITS-1:0] sh_data;
  logic [IW-1:0]            sh_last;
  logic                     sh_par, sh_par_en, sh_two;
  logic                     tx_nx, done_nx;
  logic                     accept, bit_end;
  logic [4:0]               nb;
  logic                     par_calc;

  assign tx_ready = (state == IDLE) && !cfg_break;
  assign busy     = (state != IDLE);
  assign accept   = tx_valid && tx_ready;
  assign bit_end  = baud_tick && (tick_cnt == TW'(OVERSAMPLE - 1));

  always_comb begin
    nb = {1'b0, cfg_data_bits};
    if (nb < 5'd5)
      nb = 5'd5;
    else if (nb > 5'(MAX_DATA_BITS))
      nb = 5'(MAX_DATA_BITS);
  end

  // Parity covers only the bits actually sent; higher bits of tx_data are ignored.
  always_comb begin
    par_calc = cfg_parity_odd;
    for (int i = 0; i < MAX_DATA_BITS; i++)
      if (i < int'(nb))
        par_calc = par_calc ^ tx_data[i];
  end

  always_comb begin
    state_nx = state;
    tick_nx  = tick_cnt;
    idx_nx   = bit_idx;
    done_nx  = 1'b0;
    tx_nx    = 1'b1;
    if (state != IDLE && state != BREAK && baud_tick)
      tick_nx = bit_end ? '0 : tick_cnt + 1'b1;
    case (state)
      IDLE: begin
        // Break drives the line on the same edge the state changes, in and out.
        tx_nx = !cfg_break;
        if (cfg_break) begin
          state_nx = BREAK;
        end else if (tx_valid) begin
          state_nx = START;
          tick_nx  = '0;
          idx_nx   = '0;
        end
      end
      START: begin
        tx_nx = 1'b0;
        if (bit_end) begin
          state_nx = DATA;
          idx_nx   = '0;
        end
      end
      DATA: begin
        tx_nx = sh_data[bit_idx];
        if (bit_end) begin
          if (bit_idx == sh_last) begin
            idx_nx   = '0;
            state_nx = sh_par_en ? PARITY : STOP;
          end else begin
            idx_nx = bit_idx + 1'b1;
          end
        end
      end
      PARITY: begin
        tx_nx = sh_par;
        if (bit_end)
          state_nx = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (sh_two && bit_idx == '0) begin
            idx_nx = IW'(1);
          end else begin
            idx_nx   = '0;
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      BREAK: begin
        tx_nx = !cfg_break;
        if (!cfg_break)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      tx        <= 1'b1;
      done      <= 1'b0;
      sh_data   <= '0;
      sh_last   <= '0;
      sh_par    <= 1'b0;
      sh_par_en <= 1'b0;
      sh_two    <= 1'b0;
    end else begin
      state    <= state_nx;
      tick_cnt <= tick_nx;
      bit_idx  <= idx_nx;
      tx       <= tx_nx;
      done     <= done_nx;
      if (accept) begin
        sh_data   <= tx_data;
        sh_last   <= IW'(nb - 5'd1);
        sh_par    <= par_calc;
        sh_par_en <= cfg_parity_en;
        sh_two    <= cfg_stop_two;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: samples the line mid-bit on baud ticks and checks frame length and done.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic [3:0] cfg_data_bits;
  logic       cfg_parity_en, cfg_parity_odd, cfg_stop_two, cfg_break;
  logic [8:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx, busy, done;

  int errors = 0;
  int checks = 0;
  logic phase = 1'b0;
  logic last_tick = 1'b0;

  uart_tx_frame #(.MAX_DATA_BITS(9), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick),
    .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd), .cfg_stop_two(cfg_stop_two),
    .cfg_break(cfg_break), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clk: baud tick on every other cycle; returns at the following negedge.
  task automatic clk1();
    baud_tick = (phase == 1'b0);
    phase = !phase;
    @(posedge clk);
    last_tick = baud_tick;
    @(negedge clk);
  endtask

  task automatic start(input logic [8:0] d, input logic [3:0] nbits, input logic pen,
                       input logic podd, input logic two, input logic hold);
    tx_data        = d;
    cfg_data_bits  = nbits;
    cfg_parity_en  = pen;
    cfg_parity_odd = podd;
    cfg_stop_two   = two;
    tx_valid       = 1'b1;
    chk("ready_before_accept", {31'b0, tx_ready}, 32'd1);
    clk1();
    tx_valid = hold;
  endtask

  // Records tx at tick 8 of each bit until done; action 1 scrambles cfg/data mid-frame, 2 requests break.
  task automatic capture(input int action, output logic [23:0] line, output int nticks);
    int ndone = 0;
    int ncyc = 0;
    line = '0;
    nticks = 0;
    while (ndone == 0 && ncyc < 3000) begin
      clk1();
      ncyc++;
      if (last_tick) begin
        nticks++;
        if ((nticks - 1) % 16 == 8 && (nticks - 1) / 16 < 24)
          line[(nticks - 1) / 16] = tx;
        if (action == 1 && nticks == 40) begin
          cfg_data_bits = 4'd5; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b1;
          cfg_stop_two = 1'b1; tx_data = 9'h0FF;
        end
        if (action == 1 && nticks == 100) begin
          cfg_data_bits = 4'd8; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0;
          cfg_stop_two = 1'b0;
        end
        if (action == 2 && nticks == 40)
          cfg_break = 1'b1;
      end
      if (done) ndone++;
    end
    chk("done_seen", ndone, 1);
  endtask

  task automatic frame_chk(input string tag, input logic [23:0] line, input int nt,
                           input logic [23:0] exp_line, input int exp_nt);
    chk({tag, "_bits"}, {8'b0, line}, {8'b0, exp_line});
    chk({tag, "_ticks"}, nt, exp_nt);
  endtask

  initial begin
    logic [23:0] line;
    int nt;
    int n;
    int dcnt;
    rst = 1'b1; baud_tick = 1'b0; cfg_data_bits = 4'd8; cfg_parity_en = 1'b0;
    cfg_parity_odd = 1'b0; cfg_stop_two = 1'b0; cfg_break = 1'b0;
    tx_data = '0; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clk1();
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_ready", {31'b0, tx_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
    start(9'h0A5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(0, line, nt);
    frame_chk("8n1_a5", line, nt, 24'h00034A, 160);
    chk("8n1_busy_after", {31'b0, busy}, 32'd0);
    chk("8n1_ready_after", {31'b0, tx_ready}, 32'd1);

    // 5O2 0x15: 0,1,0,1,0,1,0,1,1
    start(9'h015, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    capture(0, line, nt);
    frame_chk("5o2_15", line, nt, 24'h0001AA, 144);

    // 9E1 0x1FF: start, nine 1s, parity 1, stop
    start(9'h1FF, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    capture(0, line, nt);
    frame_chk("9e1_1ff", line, nt, 24'h000FFE, 192);

    // 3 bits clamps to 5; upper data bits excluded from even parity: 0,1,0,1,0,1,1,1
    start(9'h1F5, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    capture(0, line, nt);
    frame_chk("clamp_lo", line, nt, 24'h0000EA, 128);

    // 15 bits clamps to 9: 0x155 -> 0,1,0,1,0,1,0,1,0,1,1
    start(9'h155, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(0, line, nt);
    frame_chk("clamp_hi", line, nt, 24'h0006AA, 176);

    // Back-to-back 0x00 then 0xFF with tx_valid held, cfg disturbed mid-frame
    start(9'h000, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    capture(1, line, nt);
    frame_chk("b2b_first", line, nt, 24'h000200, 160);
    clk1();
    chk("b2b_accept_busy", {31'b0, busy}, 32'd1);
    chk("b2b_idle_high", {31'b0, tx}, 32'd1);
    tx_valid = 1'b0;
    capture(0, line, nt);
    frame_chk("b2b_second", line, nt, 24'h0003FE, 160);

    // Break requested mid-frame waits for the frame
    start(9'h0A5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(2, line, nt);
    frame_chk("brk_frame", line, nt, 24'h00034A, 160);
    clk1();
    chk("brk_tx", {31'b0, tx}, 32'd0);
    chk("brk_ready", {31'b0, tx_ready}, 32'd0);
    chk("brk_busy", {31'b0, busy}, 32'd1);
    cfg_break = 1'b0;
    clk1();
    chk("brk_exit_tx", {31'b0, tx}, 32'd1);
    chk("brk_exit_busy", {31'b0, busy}, 32'd0);
    chk("brk_exit_ready", {31'b0, tx_ready}, 32'd1);

    // Reset in the middle of data bit 3 of 0xA5 (line 0 there)
    start(9'h0A5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (n < 72) begin
      clk1();
      if (last_tick) n++;
    end
    chk("pre_rst_bit3", {31'b0, tx}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid_tx", {31'b0, tx}, 32'd1);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_done", {31'b0, done}, 32'd0);
    clk1();
    clk1();
    rst = 1'b0;
    dcnt = 0;
    repeat (300) begin
      clk1();
      if (done) dcnt++;
    end
    chk("rst_no_done", dcnt, 0);
    // 0x3C: 0,0,0,1,1,1,1,0,0,1
    start(9'h03C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(0, line, nt);
    frame_chk("post_rst", line, nt, 24'h000278, 160);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
